mips_register_file: RTL
=======================

// Module: mips_register_file
//
// PURPOSE
// - 32 x 32-bit MIPS general-purpose register file; receiving end of the 5-bit write-register select.
// - The 5-bit write address is decoded to a one-hot write enable, and write_data is stored on the clock edge.
// - Two combinational read ports feed the ID stage; register $0 reads as zero at all times.
// - Sits between decode (read ports) and write-back (write port) of the 32-bit datapath.
//
// PARAMETERS
// - DATA_WIDTH  32  width of each register and of the data ports.
// - ADDR_WIDTH   5  register address width; fixed at 5 (32 registers), any other value is unsupported.
// - BYPASS       1  1 = same-cycle write-to-read forwarding on both read ports; 0 = no forwarding.
//
// PORTS
// - clk         input   1           single clock; all state updates on rising edge.
// - rst_n       input   1           reset, asynchronous, active-low.
// - reg_write   input   1           write enable from the write-back stage.
// - write_reg   input   ADDR_WIDTH  destination register (output of the rt/rd select).
// - write_data  input   DATA_WIDTH  value to store.
// - read_reg1   input   ADDR_WIDTH  read port 1 address (rs).
// - read_reg2   input   ADDR_WIDTH  read port 2 address (rt).
// - read_data1  output  DATA_WIDTH  read port 1 data.
// - read_data2  output  DATA_WIDTH  read port 2 data.
//
// BEHAVIOUR
// - Reset: rst_n low immediately clears all 32 registers to 0, without waiting for clk.
//   - Both read_data outputs are 0 while reset is held.
//   - Reset overrides any write pending on the same edge; writes resume on the first rising edge after rst_n goes high.
// - Write decode: write_reg drives a 5-to-32 decoder, giving one-hot wen[31:0].
//   - wen[i] = reg_write & (write_reg == i).
//   - wen[0] is forced to 0.
// - Write: on a rising clk edge with wen[i]=1, register i <= write_data. Latency is 1 cycle.
//   - All other registers hold their value.
//   - reg_write=0 means no register changes, whatever write_reg holds.
// - Read: read_dataN = reg[read_regN], combinational with 0-cycle latency.
//   - Address 0 always returns 0.
// - Bypass (BYPASS=1): read_dataN = write_data when all of these hold:
//   - reg_write=1,
//   - write_reg == read_regN,
//   - write_reg != 0.
// - Bypass applies to each port independently; both ports may forward the same value in one cycle.
// - BYPASS=0: a read of the register being written returns the old value until after the edge.
// - A write to $0 is silently dropped: no state change and no forwarding.
// - Both read ports on the same address must return identical data.
// - No internal state besides the 31 writable registers; no stall or handshake signals.
//
// TESTING
// - Reset: write 0xDEADBEEF to $5, pulse rst_n low between edges -> read_reg1=5 reads 0 immediately, before the next edge.
// - Basic write/read: reg_write=1, write_reg=8, write_data=0x12345678, one edge -> read_reg1=8 and read_reg2=8 both return 0x12345678.
// - $0 protection: reg_write=1, write_reg=0, write_data=0xFFFFFFFF -> read_data1 stays 0 before and after the edge.
// - Bypass: BYPASS=1, $9=0x11, same cycle reg_write=1, write_reg=9, write_data=0x22, read_reg2=9:
//   - read_data2=0x22 before the edge.
//   - With BYPASS=0, read_data2=0x11 until the edge.
// - Write gating: reg_write=0, write_reg=3, write_data=0xAAAA -> $3 keeps its old value.
//   - Then sweep write_reg 1..31, writing value = index -> every register reads back its own index and $0 reads 0.
// - Reset priority: rst_n falls coincident with a write edge to $7=0x55 -> $7 reads 0 after reset releases.

Source files
------------

// File: rtl/mips_register_file.sv
// mips_register_file
// 32 x 32-bit MIPS general-purpose register file. One write port driven by the
// write-back stage through a one-hot decoder, two combinational read ports for
// the decode stage. Register $0 is hardwired to zero and has no storage.
// Optional same-cycle write-to-read forwarding is selected with BYPASS.

module mips_register_file #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,   // fixed at 5: 32 architectural registers
  parameter bit BYPASS     = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  reg_write,
  input  logic [ADDR_WIDTH-1:0] write_reg,
  input  logic [DATA_WIDTH-1:0] write_data,
  input  logic [ADDR_WIDTH-1:0] read_reg1,
  input  logic [ADDR_WIDTH-1:0] read_reg2,
  output logic [DATA_WIDTH-1:0] read_data1,
  output logic [DATA_WIDTH-1:0] read_data2
);

  localparam int NUM_REGS = 1 << ADDR_WIDTH;

  // One-hot write enables; bit 0 never asserts so $0 can never be written.
  logic [NUM_REGS-1:0] wen;

  // Storage exists only for $1..$31.
  logic [DATA_WIDTH-1:0] regs_q [1:NUM_REGS-1];
  logic [DATA_WIDTH-1:0] regs_d [1:NUM_REGS-1];

  // Architectural view of all 32 registers, with $0 reading as zero.
  logic [DATA_WIDTH-1:0] rf_view [0:NUM_REGS-1];

  // Unforwarded read values and forwarding selects per port.
  logic [DATA_WIDTH-1:0] rd1_raw, rd2_raw;
  logic                  fwd1, fwd2;

  // Decode the write address into a one-hot enable, gated by reg_write.
  always_comb begin
    // NOTE: every signal written in a combinational block gets a default first,
    // so no path leaves it unassigned and no latch is inferred.
    wen = '0;
    for (int i = 1; i < NUM_REGS; i++) begin
      wen[i] = reg_write && (write_reg == ADDR_WIDTH'(i));
    end
  end

  // Next-state: the enabled register takes write_data, all others hold.
  always_comb begin
    for (int i = 1; i < NUM_REGS; i++) begin
      regs_d[i] = wen[i] ? write_data : regs_q[i];
    end
  end

  // Register storage with asynchronous clear; reset wins over a coincident write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the whole array is cleared on reset because software relies on
      // every register reading zero after reset; this keeps it in flops, not RAM.
      for (int i = 1; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples its pre-edge value regardless of statement order.
      for (int i = 1; i < NUM_REGS; i++) begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

  // Build the 32-entry read view with $0 tied to zero.
  always_comb begin
    rf_view[0] = '0;
    for (int i = 1; i < NUM_REGS; i++) begin
      rf_view[i] = regs_q[i];
    end
  end

  // Raw array reads and forwarding decisions for both ports.
  always_comb begin
    rd1_raw = rf_view[read_reg1];
    rd2_raw = rf_view[read_reg2];
    // wen already excludes $0, so a dropped write to $0 never forwards.
    fwd1    = BYPASS && wen[read_reg1];
    fwd2    = BYPASS && wen[read_reg2];
  end

  // Output mux: zero while reset is held, else forwarded or stored value.
  always_comb begin
    read_data1 = '0;
    read_data2 = '0;
    if (rst_n) begin
      read_data1 = fwd1 ? write_data : rd1_raw;
      read_data2 = fwd2 ? write_data : rd2_raw;
    end
  end

endmodule
